// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: renders a 4x4 2048 board as 24-bit RGB behind the VGA timing controller.
// Define TILE_OUTLINE_EN to draw a two-pixel 776E65 outline around non-empty tiles.
module vga_tile_renderer #(
   parameter int BOARD_X0 = 84,
   parameter int BOARD_Y0 = 4,
   parameter int TILE_PX  = 108,
   parameter int GAP_PX   = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [9:0]  xCount,
   input  logic [9:0]  yCount,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        blank_n_in,
   input  logic [63:0] board_in,
   input  logic        board_valid,
   output logic        board_ready,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        blank_n_out,
   output logic        frame_start
);
   localparam int PITCH    = TILE_PX + GAP_PX;
   localparam int BOARD_PX = 4 * TILE_PX + 5 * GAP_PX;
   localparam logic [1:0] R_OUT = 2'd0, R_GAP = 2'd1, R_TILE = 2'd2;
   localparam logic [23:0] PAL [16] = '{
      24'hCDC1B4, 24'hEEE4DA, 24'hEDE0C8, 24'hF2B179, 24'hF59563, 24'hF67C5F, 24'hF65E3B, 24'hEDCF72,
      24'hEDCC61, 24'hEDC850, 24'hEDC53F, 24'hEDC22E, 24'h3C3A32, 24'h3C3A32, 24'h3C3A32, 24'h3C3A32};

   logic [63:0] active_q, active_d, pending_q, pending_d;
   logic        pending_full_q, pending_full_d, commit, take;
   logic [1:0]  reg1_q, reg1_d, reg2_q, reg2_d;
   logic [1:0]  col_q, col_d, row_q, row_d;
   logic [3:0]  nib_q, nib_d;
   logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d;
   logic [23:0] rgb_q, rgb_d, tile_rgb;
`ifdef TILE_OUTLINE_EN
   localparam int OW = $clog2(TILE_PX);
   logic [OW-1:0] offx_q, offx_d, offy_q, offy_d;
   logic          outline_q, outline_d;
`endif

   assign commit      = xCount == 10'd640 && yCount == 10'd480;
   assign take        = board_valid && !pending_full_q;
   assign board_ready = !pending_full_q;
   assign frame_start = resetn && commit;
   assign {red, green, blue} = rgb_q;
   assign {hsync_out, vsync_out, blank_n_out} = sync2_q;

   // A board accepted in the commit cycle itself waits for the following frame.
   always_comb begin
      pending_d      = take ? board_in : pending_q;
      pending_full_d = take || (pending_full_q && !commit);
      active_d       = (commit && pending_full_q) ? pending_q : active_q;
   end

   always_comb begin
      int  x, y;
      logic tx, ty;
      x = int'(xCount);
      y = int'(yCount);
      tx = 1'b0;
      ty = 1'b0;
      col_d = 2'd0;
      row_d = 2'd0;
`ifdef TILE_OUTLINE_EN
      offx_d = '0;
      offy_d = '0;
`endif
      for (int i = 0; i < 4; i++) begin
         if (x >= BOARD_X0 + GAP_PX + i * PITCH && x < BOARD_X0 + GAP_PX + i * PITCH + TILE_PX) begin
            tx = 1'b1;
            col_d = 2'(i);
`ifdef TILE_OUTLINE_EN
            offx_d = OW'(x - BOARD_X0 - GAP_PX - i * PITCH);
`endif
         end
         if (y >= BOARD_Y0 + GAP_PX + i * PITCH && y < BOARD_Y0 + GAP_PX + i * PITCH + TILE_PX) begin
            ty = 1'b1;
            row_d = 2'(i);
`ifdef TILE_OUTLINE_EN
            offy_d = OW'(y - BOARD_Y0 - GAP_PX - i * PITCH);
`endif
         end
      end
      reg1_d = (x < BOARD_X0 || x >= BOARD_X0 + BOARD_PX || y < BOARD_Y0 || y >= BOARD_Y0 + BOARD_PX) ? R_OUT :
               (tx && ty) ? R_TILE : R_GAP;
   end

   always_comb begin
      reg2_d  = reg1_q;
      nib_d   = 4'(active_q >> {row_q, col_q, 2'b00});
      sync1_d = {hsync_in, vsync_in, blank_n_in};
      sync2_d = sync1_q;
`ifdef TILE_OUTLINE_EN
      outline_d = reg1_q == R_TILE && nib_d != 4'd0 &&
                  (int'(offx_q) < 2 || int'(offx_q) >= TILE_PX - 2 ||
                   int'(offy_q) < 2 || int'(offy_q) >= TILE_PX - 2);
      tile_rgb  = outline_q ? 24'h776E65 : PAL[nib_q];
`else
      tile_rgb  = PAL[nib_q];
`endif
      // sync1_q[0] is the blank_n that will sit beside this colour on the outputs
      rgb_d = (!sync1_q[0] || reg2_q == R_OUT) ? 24'h000000 : reg2_q == R_GAP ? 24'hBBADA0 : tile_rgb;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         active_q       <= '0;
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         reg1_q         <= R_OUT;
         reg2_q         <= R_OUT;
         col_q          <= 2'd0;
         row_q          <= 2'd0;
         nib_q          <= 4'd0;
         sync1_q        <= 3'b110;
         sync2_q        <= 3'b110;
         rgb_q          <= 24'h000000;
`ifdef TILE_OUTLINE_EN
         offx_q         <= '0;
         offy_q         <= '0;
         outline_q      <= 1'b0;
`endif
      end else begin
         active_q       <= active_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         reg1_q         <= reg1_d;
         reg2_q         <= reg2_d;
         col_q          <= col_d;
         row_q          <= row_d;
         nib_q          <= nib_d;
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         rgb_q          <= rgb_d;
`ifdef TILE_OUTLINE_EN
         offx_q         <= offx_d;
         offy_q         <= offy_d;
         outline_q      <= outline_d;
`endif
      end
   end
endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb_vga_tile_renderer: directed tables, hand sequences and random counters against a
// frame-level model of the board renderer (honours TILE_OUTLINE_EN).
module tb_vga_tile_renderer;
   localparam logic [23:0] PAL [16] = '{
      24'hCDC1B4, 24'hEEE4DA, 24'hEDE0C8, 24'hF2B179, 24'hF59563, 24'hF67C5F, 24'hF65E3B, 24'hEDCF72,
      24'hEDCC61, 24'hEDC850, 24'hEDC53F, 24'hEDC22E, 24'h3C3A32, 24'h3C3A32, 24'h3C3A32, 24'h3C3A32};
   localparam int HN = 16384;

   logic        clk = 1'b0, resetn = 1'b0;
   logic [9:0]  xCount = '0, yCount = '0;
   logic        hsync_in = 1'b1, vsync_in = 1'b1, blank_n_in = 1'b0;
   logic [63:0] board_in = '0;
   logic        board_valid = 1'b0;
   logic        board_ready, hsync_out, vsync_out, blank_n_out, frame_start;
   logic [7:0]  red, green, blue;

   always #5 clk = ~clk;

   vga_tile_renderer dut (
      .clk(clk), .resetn(resetn), .xCount(xCount), .yCount(yCount),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_n_in(blank_n_in),
      .board_in(board_in), .board_valid(board_valid), .board_ready(board_ready),
      .red(red), .green(green), .blue(blue),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_n_out(blank_n_out),
      .frame_start(frame_start));

   int pass_cnt = 0, total = 0, cyc = 0, px = 0, py = 0;
   logic [63:0] m_active = '0, m_pending = '0;
   logic        m_full = 1'b0;
   logic [23:0] col_h [HN];
   logic        hs_h [HN], vs_h [HN], bn_h [HN], rs_h [HN];

   typedef struct {int x; int y; logic [23:0] rgb;} vec_t;
   vec_t tbl [12];

   function automatic logic [23:0] colour(input int x, input int y, input logic [63:0] b);
      int ox, oy, mx, my, v;
      ox = x - 84;
      oy = y - 4;
      if (ox < 0 || oy < 0 || ox >= 472 || oy >= 472) return 24'h000000;
      mx = ox % 116;
      my = oy % 116;
      if (mx < 8 || my < 8) return 24'hBBADA0;
      v = int'(b[((oy / 116) * 4 + ox / 116) * 4 +: 4]);
`ifdef TILE_OUTLINE_EN
      if (v != 0 && (mx - 8 < 2 || mx - 8 >= 106 || my - 8 < 2 || my - 8 >= 106)) return 24'h776E65;
`endif
      return PAL[v];
   endfunction

   function automatic logic rs_at(input int k); return k < 0 ? 1'b1 : rs_h[k]; endfunction
   function automatic logic hs_at(input int k); return k < 0 ? 1'b1 : hs_h[k]; endfunction
   function automatic logic vs_at(input int k); return k < 0 ? 1'b1 : vs_h[k]; endfunction
   function automatic logic bn_at(input int k); return k < 0 ? 1'b0 : bn_h[k]; endfunction
   function automatic logic [23:0] col_at(input int k); return k < 0 ? 24'h0 : col_h[k]; endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      else pass_cnt++;
   endtask

   // Apply one cycle of inputs; sync inputs lag the counters by one cycle like the controller.
   task automatic drive(input int x, input int y, input logic v, input logic [63:0] b, input logic rn);
      logic z2, z3;
      xCount = 10'(x);
      yCount = 10'(y);
      board_valid = v;
      board_in = b;
      resetn = rn;
      hsync_in = !(px >= 656 && px < 752);
      vsync_in = !(py == 490 || py == 491);
      blank_n_in = px < 640 && py < 480;
      px = x;
      py = y;
      #1;
      if (rn) begin
         chk("board_ready", board_ready, !m_full);
         chk("frame_start", frame_start, x == 640 && y == 480);
      end else chk("frame_start_rst", frame_start, 0);
      if (cyc > 0) begin
         z2 = rs_at(cyc - 1) || rs_at(cyc - 2);
         z3 = z2 || rs_at(cyc - 3);
         chk("hsync_out", hsync_out, z2 ? 1'b1 : hs_at(cyc - 2));
         chk("vsync_out", vsync_out, z2 ? 1'b1 : vs_at(cyc - 2));
         chk("blank_n_out", blank_n_out, z2 ? 1'b0 : bn_at(cyc - 2));
         chk("rgb", {red, green, blue}, (z3 || !bn_at(cyc - 2)) ? 24'h0 : col_at(cyc - 3));
      end
   endtask

   task automatic tick();
      col_h[cyc] = colour(int'(xCount), int'(yCount), m_active);
      hs_h[cyc] = hsync_in;
      vs_h[cyc] = vsync_in;
      bn_h[cyc] = blank_n_in;
      rs_h[cyc] = !resetn;
      @(posedge clk);
      if (!resetn) begin
         m_active = '0;
         m_full = 1'b0;
      end else if (board_valid && !m_full) begin
         m_pending = board_in;
         m_full = 1'b1;
      end else if (xCount == 10'd640 && yCount == 10'd480 && m_full) begin
         m_active = m_pending;
         m_full = 1'b0;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic step(input int x, input int y, input logic v, input logic [63:0] b, input logic rn);
      drive(x, y, v, b, rn);
      tick();
   endtask

   task automatic show(input int x, input int y, input logic [23:0] exp, input string name);
      step(x, y, 1'b0, '0, 1'b1);
      step(10, 10, 1'b0, '0, 1'b1);
      step(10, 10, 1'b0, '0, 1'b1);
      chk(name, {red, green, blue}, exp);
   endtask

   initial begin
      logic [63:0] b1, b3, b4;
      b1 = 64'hB << 20;
      b3 = b1 | 64'h2;
      b4 = 64'h1;
      tbl = '{
         '{92, 12, 24'hCDC1B4}, '{88, 12, 24'hBBADA0}, '{10, 10, 24'h000000}, '{199, 12, 24'hCDC1B4},
         '{200, 12, 24'hBBADA0}, '{84, 4, 24'hBBADA0}, '{83, 4, 24'h000000}, '{555, 475, 24'hBBADA0},
         '{556, 100, 24'h000000}, '{100, 476, 24'h000000}, '{92, 11, 24'hBBADA0}, '{523, 463, 24'hCDC1B4}};
      @(negedge clk);
      drive(640, 480, 1'b0, '0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) step(300, 200, 1'b1, b1, 1'b0);
      chk("rst_rgb", {red, green, blue}, 24'h0);
      chk("rst_hsync", hsync_out, 1'b1);
      chk("rst_blank", blank_n_out, 1'b0);
      step(10, 10, 1'b0, '0, 1'b1);
      for (int i = 0; i < 12; i++) show(tbl[i].x, tbl[i].y, tbl[i].rgb, $sformatf("tbl%0d", i));

      step(300, 200, 1'b1, b1, 1'b1);
      chk("ready_drop", board_ready, 1'b0);
      for (int i = 0; i < 4; i++) step(300, 200, 1'b1, 64'h3 << 20, 1'b1);
      show(300, 200, 24'hCDC1B4, "old_frame");
      drive(640, 480, 1'b0, '0, 1'b1);
      chk("commit_pulse", frame_start, 1'b1);
      chk("ready_low_at_commit", board_ready, 1'b0);
      tick();
      chk("ready_rise", board_ready, 1'b1);
      show(300, 200, 24'hEDC22E, "new_tile5");
      show(100, 20, 24'hCDC1B4, "tile0_empty");

      drive(640, 480, 1'b1, b3, 1'b1);
      chk("xfer_commit_pulse", frame_start, 1'b1);
      chk("xfer_commit_ready", board_ready, 1'b1);
      tick();
      chk("ready_after_xfer", board_ready, 1'b0);
      show(100, 20, 24'hCDC1B4, "not_yet_committed");
      step(640, 480, 1'b0, '0, 1'b1);
      show(100, 20, 24'hEDE0C8, "committed_next");

      step(656, 100, 1'b0, '0, 1'b1);
      step(10, 10, 1'b0, '0, 1'b1);
      step(10, 10, 1'b0, '0, 1'b1);
      chk("hsync_fall", hsync_out, 1'b0);
      step(10, 10, 1'b0, '0, 1'b1);
      chk("hsync_rise", hsync_out, 1'b1);

      step(0, 0, 1'b1, b4, 1'b1);
      step(640, 480, 1'b0, '0, 1'b1);
`ifdef TILE_OUTLINE_EN
      show(92, 62, 24'h776E65, "tile0_edge");
`else
      show(92, 62, 24'hEEE4DA, "tile0_edge");
`endif
      show(142, 62, 24'hEEE4DA, "tile0_inner");
      for (int i = 0; i < 3; i++) step(142, 62, 1'b1, b1, 1'b0);
      chk("midrst_rgb", {red, green, blue}, 24'h0);
      chk("midrst_blank", blank_n_out, 1'b0);
      show(142, 62, 24'hCDC1B4, "post_reset_cleared");
      chk("post_reset_ready", board_ready, 1'b1);
      show(92, 62, 24'hCDC1B4, "empty_edge");

      for (int i = 0; i < 2500; i++) begin
         int x, y;
         if ($urandom_range(0, 39) == 0) begin
            x = 640;
            y = 480;
         end else begin
            x = int'($urandom_range(0, 799));
            y = int'($urandom_range(0, 524));
         end
         step(x, y, $urandom_range(0, 3) == 0, {$urandom(), $urandom()}, $urandom_range(0, 299) != 0);
      end
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/vga_tile_renderer.md
# vga_tile_renderer

Pixel-generation stage directly downstream of the VGA timing controller. It takes the controller's pixel counters and sync/blank outputs and a 16-tile 2048 board state, and produces 24-bit RGB for a 4x4 tile grid. Sync and blank outputs are re-timed so that they stay aligned with the colour pipeline. Board updates arrive through a valid/ready handshake and are committed only at the start of vertical blanking, so a frame never tears.

## Interface
Parameters:
- BOARD_X0, 84: left pixel column of the board (outer gap edge).
- BOARD_Y0, 4: top pixel row of the board.
- TILE_PX, 108: tile edge length in pixels.
- GAP_PX, 8: gap width between tiles and around the board edge. Board extent is 4*TILE_PX+5*GAP_PX = 472 px square.

Ports:
- clk  in  1  pixel clock, same clock as the timing controller.
- resetn  in  1  synchronous, active-low reset.
- xCount  in  10  pixel column from the timing controller.
- yCount  in  10  pixel row from the timing controller.
- hsync_in  in  1  active-low hsync; lags xCount/yCount by 1 cycle.
- vsync_in  in  1  active-low vsync; lags xCount/yCount by 1 cycle.
- blank_n_in  in  1  active-high display enable; lags xCount/yCount by 1 cycle.
- board_in  in  64  16 nibbles; nibble i = tile i in row-major order, tile 0 top-left at bits [3:0]; value v means 2^v, and 0 means empty.
- board_valid  in  1  board_in is valid.
- board_ready  out  1  block can accept a board.
- red, green, blue  out  8 each  pixel colour.
- hsync_out, vsync_out, blank_n_out  out  1 each  re-timed sync and enable signals.
- frame_start  out  1  one-cycle pulse on each commit opportunity.

## Operation
- Registers: active board (used for rendering), pending board, and a pending_full flag. board_ready = ~pending_full.
- Handshake: on board_valid && board_ready, board_in is loaded into pending and pending_full is set. Holding board_valid while ready is low has no effect.
- Commit point: the cycle in which xCount==640 and yCount==480 are sampled. In that cycle frame_start=1. If pending_full is set, active <= pending and pending_full clears, so board_ready is 1 on the next cycle.
- Transfer in the commit cycle: a transfer in that cycle is possible only if pending was empty. Nothing is committed that cycle. The board just transferred waits in pending for the next frame's commit.
- Pipeline stage 1: classify (xCount, yCount) with parameter compares into outside / gap / tile. For a tile, register col and row (0-3) and the in-tile offsets.
- Pipeline stage 2: select nibble row*4+col from the active board and register it with the region.
- Pipeline stage 3: colour lookup, registered to red/green/blue.
- Palette:
  - Outside the board: 000000.
  - Gap: BBADA0.
  - Value 0: CDC1B4.
  - Values 1-11: EEE4DA, EDE0C8, F2B179, F59563, F67C5F, F65E3B, EDCF72, EDCC61, EDC850, EDC53F, EDC22E.
  - Values 12-15: 3C3A32.
- Blanking: when the aligned blank_n is 0, RGB is forced to 000000.
- Active board stability: the active board changes only in the commit cycle, which lies in vertical blank. Any in-flight pixel is therefore blanked.

## Timing
- RGB latency: RGB for counter value (x, y) appears 3 cycles after (x, y) is presented.
- Sync/blank alignment: hsync_in, vsync_in and blank_n_in pass through a 2-stage delay. All six outputs are therefore mutually aligned.
- frame_start is combinationally decoded from the registered counters: it is high in the same cycle in which the commit-point counter values are present.
- Reset values (resetn=0 sampled):
  - red, green, blue = 0; hsync_out = 1; vsync_out = 1; blank_n_out = 0; frame_start = 0.
  - Delay pipeline filled with the same idle values.
  - Active board = 0; pending_full = 0, so board_ready = 1 on the first cycle after reset is released.
- Reset mid-frame: the behaviour above applies immediately on the next edge. Rendering resumes correctly at the next counter values after release. No board is committed until the next commit point.
- Tile boundaries:
  - Column c spans BOARD_X0+GAP_PX+c*(TILE_PX+GAP_PX) to +TILE_PX-1, inclusive; rows follow the same rule.
  - The first tile pixel is x=92 and the last is x=199. Pixel x=200 is gap.
- Counter wrap: no special case; classification is purely from the counter values.

## Configuration
- TILE_OUTLINE_EN defined: in tiles with nonzero value, pixels with in-tile offset 0, 1, TILE_PX-2 or TILE_PX-1 on either axis render 776E65. Latency is unchanged.
- TILE_OUTLINE_EN undefined: tiles are solid palette colour. The offset logic is removed.

## Test plan
- Reset, then free-run the counters: outputs hold idle values during reset. After release, with an empty board, pixel (92, 12) -> CDC1B4 and pixel (88, 12) -> BBADA0, each 3 cycles after the counters are presented; pixel (10, 10) -> 000000.
- Load a board with tile 5 = 11, mid-frame: board_ready drops the next cycle. The current frame keeps its old colours. At the commit point frame_start pulses and board_ready rises 1 cycle later. Next frame, (300, 200) -> EDC22E.
- Hold board_valid while ready is low with a different board: it is ignored, and only the first board is committed.
- Transfer in the commit cycle with pending empty: not committed in that frame; committed one frame later.
- Sync alignment: hsync_in/blank_n_in edges reappear on the outputs exactly 2 cycles later. RGB is 000000 whenever blank_n_out = 0.
- TILE_OUTLINE_EN build: tile 0 = 1, offset (0, 50) -> 776E65 and offset (50, 50) -> EEE4DA. With tile 0 = 0, offset (0, 50) -> CDC1B4.
